fu_pipe_unit: RTL and testbench
===============================

// Module: fu_pipe_unit
// PURPOSE
//   Parametrised, pipelined PE functional unit. Generalises the PE FU to any
//   width, with a configurable multiplier latency, full valid/ready backpressure,
//   optional saturating arithmetic and a multiply-accumulate (MAC) mode.
//   Sits between the PE operand muxes and the PE output register.
//   Results leave in order; groups of accumulated beats produce one result.
// PARAMETERS
//   N_BITS     32  datapath width, signed two's complement (>=8)
//   ACC_CNT_W  16  accumulation length counter width
//   MUL_LAT    2   pipeline depth (1..4) applied uniformly to all ops
//   SATURATE   0   1: ADD/SUB/ABS/ACC/MAC clamp to signed range; 0: wrap
// PORTS
//   clk_i        in   1          clock
//   rst_i        in   1          synchronous reset, active-high
//   flush_i      in   1          synchronous pipeline/accumulator clear
//   op_i         in   4          opcode, sampled with each accepted beat
//   a_i          in   N_BITS     operand A
//   b_i          in   N_BITS     operand B (shift amount = b_i[$clog2(N_BITS)-1:0])
//   const_i      in   N_BITS     configuration constant
//   acc_len_i    in   ACC_CNT_W  accumulated beats minus one, sampled on first beat
//   in_valid_i   in   1          operand beat valid
//   in_ready_o   out  1          unit accepts a beat this cycle
//   out_valid_o  out  1          res_o valid
//   out_ready_i  in   1          consumer accepts res_o
//   res_o        out  N_BITS     result
//   acc_abort_o  out  1          1-cycle pulse: partial accumulation discarded
// BEHAVIOUR
// - Opcodes: 0 NOP (res 0), 1 ADD, 2 SUB a-b, 3 MUL a*b, 4 ARSH, 5 LRSH, 6 LSH,
//   7 MAX, 8 MIN (signed), 9 ABS a, 10 ACC (sum a), 11 MAC (sum a*b),
//   12 CMUL a*const_i. 13..15 reserved: res 0.
// - MUL/CMUL/MAC keep the low N_BITS of the product (wrap, even when SATURATE=1).
// - Reset: out_valid_o=0, res_o=0, acc_abort_o=0, FSM=IDLE, counter=0, acc=0.
// - Handshake:
//   - stall = out_valid_o & ~out_ready_i; in_ready_o = ~stall (combinational).
//   - A beat is accepted on in_valid_i & in_ready_o.
//   - The whole pipeline and the accumulator hold while stall is high.
//   - out_valid_o/res_o stay stable until accepted.
// - Latency: a non-accumulating beat appears at res_o exactly MUL_LAT cycles
//   after acceptance when there is no backpressure. Throughput is 1 beat/cycle.
// - Accumulation FSM, updated at the last pipeline stage:
//   - IDLE: first ACC/MAC beat loads acc=term and cnt=0, and latches len=acc_len_i.
//     - If len==0, the result is emitted immediately and the FSM stays in IDLE.
//     - Otherwise the FSM goes to ACCUM with no output.
//   - ACCUM: each ACC/MAC beat does acc+=term and cnt+=1.
//     - When cnt reaches len, the result is emitted and the FSM goes to IDLE.
//   - ACCUM with a non-ACC/MAC beat: the partial sum is dropped and acc_abort_o
//     pulses. The beat is processed normally and the FSM goes to IDLE.
//   - An ACC<->MAC change within a group is legal. The term type follows each beat.
// - SATURATE=1:
//   - Overflow clamps to 2^(N_BITS-1)-1 or -2^(N_BITS-1).
//   - ABS(-2^(N_BITS-1)) gives 2^(N_BITS-1)-1.
// - SATURATE=0: all arithmetic wraps modulo 2^N_BITS.
// - flush_i wins over all other activity.
//   - It clears the pipeline valids, out_valid_o, acc, cnt and the FSM.
//   - A beat presented in the same cycle is dropped.
// - rst_i mid-group behaves as flush_i and does not pulse acc_abort_o.
// TESTING (N_BITS=32, MUL_LAT=2)
// - MUL a=7,b=-3 accepted at cycle t -> res_o=-21, out_valid_o=1 at t+2.
// - Stream ADD 1+1, 2+2, 3+3 with out_ready_i=0 for 3 cycles, then 1 ->
//   in_ready_o=0 while stalled; results 2,4,6 in order, none lost or duplicated.
// - MAC acc_len_i=3, (a,b)=(1,2),(3,4),(5,6),(7,8) -> single result 100,
//   exactly 1 out_valid_o beat.
// - SATURATE=1: ADD 0x7FFFFFFF+1 -> 0x7FFFFFFF; ABS 0x80000000 -> 0x7FFFFFFF.
//   SATURATE=0: the same ADD gives 0x80000000.
// - ACC acc_len_i=4, 2 beats then SUB 9-4 -> acc_abort_o pulse, output 5 only.
// - flush_i during ACCUM and during stall -> out_valid_o=0 next cycle; the next
//   ACC group with acc_len_i=0, a=9 outputs 9.

Source files
------------

// File: rtl/fu_pipe_unit.sv
// rtl/fu_pipe_unit.sv - pipelined PE functional unit with backpressure, saturation and MAC
module fu_pipe_unit #(
    parameter int N_BITS    = 32,
    parameter int ACC_CNT_W = 16,
    parameter int MUL_LAT   = 2,
    parameter int SATURATE  = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic [3:0]           op_i,
    input  logic [N_BITS-1:0]    a_i,
    input  logic [N_BITS-1:0]    b_i,
    input  logic [N_BITS-1:0]    const_i,
    input  logic [ACC_CNT_W-1:0] acc_len_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [N_BITS-1:0]    res_o,
    output logic                 acc_abort_o
);
    localparam int SH_W = $clog2(N_BITS);
    localparam logic [N_BITS-1:0] S_MAX = {1'b0, {(N_BITS-1){1'b1}}};
    localparam logic [N_BITS-1:0] S_MIN = {1'b1, {(N_BITS-1){1'b0}}};

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_ARSH = 4'd4;
    localparam logic [3:0] OP_LRSH = 4'd5;
    localparam logic [3:0] OP_LSH  = 4'd6;
    localparam logic [3:0] OP_MAX  = 4'd7;
    localparam logic [3:0] OP_MIN  = 4'd8;
    localparam logic [3:0] OP_ABS  = 4'd9;
    localparam logic [3:0] OP_ACC  = 4'd10;
    localparam logic [3:0] OP_MAC  = 4'd11;
    localparam logic [3:0] OP_CMUL = 4'd12;

    typedef struct packed {
        logic                 valid;
        logic                 acc;
        logic [ACC_CNT_W-1:0] len;
        logic [N_BITS-1:0]    val;
    } beat_t;

    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    // One extra sign bit exposes overflow; clamping only when SATURATE is set.
    function automatic logic [N_BITS-1:0] add_sat(input logic [N_BITS-1:0] x,
                                                  input logic [N_BITS-1:0] y,
                                                  input logic sub);
        logic [N_BITS:0] s;
        s = sub ? ({x[N_BITS-1], x} - {y[N_BITS-1], y})
                : ({x[N_BITS-1], x} + {y[N_BITS-1], y});
        if (SATURATE != 0 && s[N_BITS] != s[N_BITS-1])
            return s[N_BITS] ? S_MIN : S_MAX;
        return s[N_BITS-1:0];
    endfunction

    logic              stall;
    logic              accept;
    logic [SH_W-1:0]   sh;
    beat_t             c_beat;
    beat_t             l_beat;

    assign stall      = out_valid_o & ~out_ready_i;
    assign in_ready_o = ~stall;
    assign accept     = in_valid_i & in_ready_o & ~flush_i;
    assign sh         = b_i[SH_W-1:0];

    always_comb begin
        c_beat       = '0;
        c_beat.valid = accept;
        c_beat.acc   = (op_i == OP_ACC) || (op_i == OP_MAC);
        c_beat.len   = acc_len_i;
        case (op_i)
            OP_ADD:         c_beat.val = add_sat(a_i, b_i, 1'b0);
            OP_SUB:         c_beat.val = add_sat(a_i, b_i, 1'b1);
            OP_MUL, OP_MAC: c_beat.val = a_i * b_i;
            OP_ARSH:        c_beat.val = $signed(a_i) >>> sh;
            OP_LRSH:        c_beat.val = a_i >> sh;
            OP_LSH:         c_beat.val = a_i << sh;
            OP_MAX:         c_beat.val = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
            OP_MIN:         c_beat.val = ($signed(a_i) < $signed(b_i)) ? a_i : b_i;
            OP_ABS:         c_beat.val = a_i[N_BITS-1] ? add_sat('0, a_i, 1'b1) : a_i;
            OP_ACC:         c_beat.val = a_i;
            OP_CMUL:        c_beat.val = a_i * const_i;
            default:        c_beat.val = '0;
        endcase
    end

    // MUL_LAT-1 delay stages ahead of the output register.
    if (MUL_LAT == 1) begin : g_direct
        assign l_beat = c_beat;
    end else begin : g_pipe
        beat_t stage_q [MUL_LAT-1];
        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
                for (int i = 0; i < MUL_LAT-1; i++) stage_q[i].valid <= 1'b0;
            end else if (!stall) begin
                stage_q[0] <= c_beat;
                for (int i = 1; i < MUL_LAT-1; i++) stage_q[i] <= stage_q[i-1];
            end
        end
        assign l_beat = stage_q[MUL_LAT-2];
    end

    state_t               state;
    logic [N_BITS-1:0]    acc_q;
    logic [ACC_CNT_W-1:0] cnt_q;
    logic [ACC_CNT_W-1:0] len_q;
    logic [N_BITS-1:0]    acc_sum;
    logic [ACC_CNT_W-1:0] cnt_nxt;

    assign acc_sum = add_sat(acc_q, l_beat.val, 1'b0);
    assign cnt_nxt = cnt_q + ACC_CNT_W'(1);

    always_ff @(posedge clk_i) begin
        acc_abort_o <= 1'b0;
        if (rst_i) begin
            out_valid_o <= 1'b0;
            res_o       <= '0;
            state       <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
            state       <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else if (!stall) begin
            out_valid_o <= 1'b0;
            if (l_beat.valid && l_beat.acc) begin
                if (state == S_IDLE) begin
                    acc_q <= l_beat.val;
                    cnt_q <= '0;
                    len_q <= l_beat.len;
                    if (l_beat.len == '0) begin
                        out_valid_o <= 1'b1;
                        res_o       <= l_beat.val;
                    end else begin
                        state <= S_ACCUM;
                    end
                end else begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_nxt;
                    if (cnt_nxt == len_q) begin
                        out_valid_o <= 1'b1;
                        res_o       <= acc_sum;
                        state       <= S_IDLE;
                    end
                end
            end else if (l_beat.valid) begin
                // A foreign beat mid-group discards the partial sum.
                acc_abort_o <= (state == S_ACCUM);
                state       <= S_IDLE;
                acc_q       <= '0;
                cnt_q       <= '0;
                out_valid_o <= 1'b1;
                res_o       <= l_beat.val;
            end
        end
    end
endmodule

// File: tb/tb_fu_pipe_unit.sv
// tb/tb_fu_pipe_unit.sv - randomized bench for fu_pipe_unit against a beat-level reference model
module tb_fu_pipe_unit;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, flush_i, in_valid, out_ready;
    logic [3:0]  op;
    logic [31:0] a, b, c;
    logic [15:0] len;
    logic        in_ready0, in_ready1, ov0, ov1, ab0, ab1;
    logic [31:0] res0, res1;

    fu_pipe_unit #(.N_BITS(32), .ACC_CNT_W(16), .MUL_LAT(2), .SATURATE(0)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .op_i(op), .a_i(a), .b_i(b),
        .const_i(c), .acc_len_i(len), .in_valid_i(in_valid), .in_ready_o(in_ready0),
        .out_valid_o(ov0), .out_ready_i(out_ready), .res_o(res0), .acc_abort_o(ab0));

    fu_pipe_unit #(.N_BITS(32), .ACC_CNT_W(16), .MUL_LAT(2), .SATURATE(1)) dut_s (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .op_i(op), .a_i(a), .b_i(b),
        .const_i(c), .acc_len_i(len), .in_valid_i(in_valid), .in_ready_o(in_ready1),
        .out_valid_o(ov1), .out_ready_i(out_ready), .res_o(res1), .acc_abort_o(ab1));

    typedef struct {
        logic [31:0] r0;
        logic [31:0] r1;
        bit          abort;
    } exp_t;

    exp_t        q[$];
    bit          m_grp;
    logic [31:0] m_acc0, m_acc1;
    int          m_cnt, m_len;
    int          checks = 0, errors = 0, n_out = 0, n_ab = 0, base, ab_base;
    logic [31:0] last0, last1;
    bit          fresh = 1'b1, chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [31:0] clampw(input longint x, input bit sat);
        if (sat && x > 64'sd2147483647) return 32'h7fffffff;
        if (sat && x < -64'sd2147483648) return 32'h80000000;
        return x[31:0];
    endfunction

    function automatic logic [31:0] ref_op(input logic [3:0] o, input logic [31:0] x, y, k,
                                           input bit sat);
        case (o)
            4'd1:  return clampw(sx(x) + sx(y), sat);
            4'd2:  return clampw(sx(x) - sx(y), sat);
            4'd3:  return clampw(sx(x) * sx(y), 1'b0);
            4'd4:  return $signed(x) >>> y[4:0];
            4'd5:  return x >> y[4:0];
            4'd6:  return x << y[4:0];
            4'd7:  return (sx(x) > sx(y)) ? x : y;
            4'd8:  return (sx(x) < sx(y)) ? x : y;
            4'd9:  return clampw((sx(x) < 0) ? -sx(x) : sx(x), sat);
            4'd12: return clampw(sx(x) * sx(k), 1'b0);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_beat(input logic [3:0] o, input logic [31:0] x, y, k, input logic [15:0] l);
        exp_t        e;
        logic [31:0] t;
        if (o == 4'd10 || o == 4'd11) begin
            t = (o == 4'd10) ? x : clampw(sx(x) * sx(y), 1'b0);
            if (!m_grp) begin
                m_acc0 = t; m_acc1 = t; m_cnt = 0; m_len = int'(l);
                if (l == 16'd0) begin
                    e.r0 = t; e.r1 = t; e.abort = 1'b0; q.push_back(e);
                end else m_grp = 1'b1;
            end else begin
                m_acc0 = clampw(sx(m_acc0) + sx(t), 1'b0);
                m_acc1 = clampw(sx(m_acc1) + sx(t), 1'b1);
                m_cnt++;
                if (m_cnt == m_len) begin
                    e.r0 = m_acc0; e.r1 = m_acc1; e.abort = 1'b0; q.push_back(e);
                    m_grp = 1'b0;
                end
            end
        end else begin
            e.r0 = ref_op(o, x, y, k, 1'b0);
            e.r1 = ref_op(o, x, y, k, 1'b1);
            e.abort = m_grp;
            q.push_back(e);
            m_grp = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (ab0) n_ab++;
            if (ov0 || ov1) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", {62'd0, ov0, ov1}, 64'd0);
                end else begin
                    chk("valid_s0", ov0, 1);
                    chk("valid_s1", ov1, 1);
                    chk("res_s0", res0, q[0].r0);
                    chk("res_s1", res1, q[0].r1);
                    chk("abort_s0", ab0, fresh && q[0].abort);
                    chk("abort_s1", ab1, fresh && q[0].abort);
                    if (out_ready) begin
                        last0 = res0; last1 = res1; n_out++;
                        void'(q.pop_front());
                    end
                end
            end else begin
                chk("abort_idle_s0", ab0, 0);
                chk("abort_idle_s1", ab1, 0);
            end
            fresh = !(ov0 && !out_ready);
            if (rst_i || flush_i) begin
                q.delete(); m_grp = 1'b0; fresh = 1'b1;
            end else if (in_valid && in_ready0) begin
                model_beat(op, a, b, c, len);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_accept();
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready0) break;
        end
        if (k == 100) chk("accept_timeout", 1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] o, input logic [31:0] x, y, k, input logic [15:0] l);
        in_valid = 1'b1; op = o; a = x; b = y; c = k; len = l;
        wait_accept();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 50 && q.size() != 0; k++) idle(1);
        idle(1);
        chk("drain_empty", q.size(), 0);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'h7fffffff;
            1: return 32'h80000000;
            2: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 4'd0; a = '0; b = '0; c = '0; len = '0; m_grp = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0; chk_en = 1'b1;
        chk("rst_valid", ov0, 0);
        chk("rst_res_s0", res0, 0);
        chk("rst_res_s1", res1, 0);
        chk("rst_abort", ab0, 0);
        chk("rst_ready", in_ready0, 1);

        send(4'd3, 32'd7, 32'hfffffffd, 32'd0, 16'd0);
        chk("mul_t1_valid", ov0, 0);
        idle(1);
        chk("mul_t2_valid", ov0, 1);
        chk("mul_t2_res", res0, 32'hffffffeb);
        drain();

        base = n_out; out_ready = 1'b0;
        send(4'd1, 32'd1, 32'd1, 32'd0, 16'd0);
        send(4'd1, 32'd2, 32'd2, 32'd0, 16'd0);
        in_valid = 1'b1; op = 4'd1; a = 32'd3; b = 32'd3;
        repeat (3) begin
            chk("stall_ready_s0", in_ready0, 0);
            chk("stall_ready_s1", in_ready1, 0);
            chk("stall_hold", res0, 32'd2);
            idle(1);
        end
        out_ready = 1'b1;
        wait_accept();
        drain();
        chk("stall_count", n_out - base, 3);
        chk("stall_last", last0, 32'd6);

        base = n_out;
        send(4'd11, 32'd1, 32'd2, 32'd0, 16'd3);
        send(4'd11, 32'd3, 32'd4, 32'd0, 16'd3);
        send(4'd11, 32'd5, 32'd6, 32'd0, 16'd3);
        send(4'd11, 32'd7, 32'd8, 32'd0, 16'd3);
        drain();
        chk("mac_count", n_out - base, 1);
        chk("mac_res", last0, 32'd100);

        send(4'd1, 32'h7fffffff, 32'd1, 32'd0, 16'd0); drain();
        chk("add_wrap", last0, 32'h80000000);
        chk("add_clamp", last1, 32'h7fffffff);
        send(4'd9, 32'h80000000, 32'd0, 32'd0, 16'd0); drain();
        chk("abs_wrap", last0, 32'h80000000);
        chk("abs_clamp", last1, 32'h7fffffff);
        send(4'd2, 32'h80000000, 32'd1, 32'd0, 16'd0); drain();
        chk("sub_wrap", last0, 32'h7fffffff);
        chk("sub_clamp", last1, 32'h80000000);

        base = n_out; ab_base = n_ab;
        send(4'd10, 32'd1, 32'd0, 32'd0, 16'd4);
        send(4'd10, 32'd2, 32'd0, 32'd0, 16'd4);
        send(4'd2, 32'd9, 32'd4, 32'd0, 16'd0);
        drain();
        chk("abort_pulses", n_ab - ab_base, 1);
        chk("abort_count", n_out - base, 1);
        chk("abort_res", last0, 32'd5);

        ab_base = n_ab;
        send(4'd10, 32'd5, 32'd0, 32'd0, 16'd3);
        idle(2);
        flush_i = 1'b1; idle(1); flush_i = 1'b0;
        chk("flush_accum_valid", ov0, 0);
        base = n_out;
        send(4'd10, 32'd9, 32'd0, 32'd0, 16'd0); drain();
        chk("flush_accum_count", n_out - base, 1);
        chk("flush_accum_res", last0, 32'd9);
        chk("flush_no_abort", n_ab - ab_base, 0);

        out_ready = 1'b0;
        send(4'd1, 32'd1, 32'd1, 32'd0, 16'd0);
        idle(2);
        chk("flush_stall_pre", ov0, 1);
        flush_i = 1'b1; idle(1); flush_i = 1'b0;
        chk("flush_stall_valid", ov0, 0);
        out_ready = 1'b1; base = n_out;
        send(4'd10, 32'd9, 32'd0, 32'd0, 16'd0); drain();
        chk("flush_stall_count", n_out - base, 1);
        chk("flush_stall_res", last0, 32'd9);

        ab_base = n_ab;
        send(4'd11, 32'd3, 32'd3, 32'd0, 16'd2);
        idle(2);
        rst_i = 1'b1; idle(1); rst_i = 1'b0;
        chk("rst_mid_valid", ov0, 0);
        chk("rst_mid_res", res0, 0);
        chk("rst_mid_no_abort", n_ab - ab_base, 0);

        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            op        = ($urandom_range(0, 9) < 4) ? 4'(10 + $urandom_range(0, 1))
                                                   : 4'($urandom_range(0, 15));
            a         = rand_val();
            b         = rand_val();
            c         = rand_val();
            len       = 16'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            flush_i   = ($urandom_range(0, 199) == 0);
            rst_i     = ($urandom_range(0, 499) == 0);
            idle(1);
        end
        flush_i = 1'b0; rst_i = 1'b0; in_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
